cmp_sort4_ctrl: RTL and testbench

//  Sequencing controller that sorts a packet of four WIDTH-bit values with one

---
 rtl/cmp_sort4_ctrl.sv | 158 +++++++++++++++
 tb/tb_cmp_sort4_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort4_ctrl.sv
// cmp_sort4_ctrl
//   Sorts a packet of four unsigned WIDTH-bit elements using a single shared
//   magnitude comparator. The controller performs one compare-exchange per
//   clock and walks the 5-step optimal 4-input sorting network:
//   (0,1) (2,3) (0,2) (1,3) (1,2).
//   The result is ascending when DESCEND=0 and descending when DESCEND=1.
//
// Parameters
//   WIDTH      element width in bits (unsigned compare)
//   DESCEND    0: swap when a>b (ascending), 1: swap when a<b (descending)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a packet on in_data
//   in_ready   packet can be accepted (IDLE only)
//   in_data    element i at [i*WIDTH +: WIDTH]
//   out_valid  sorted packet available (DONE only)
//   out_ready  consumer takes the sorted packet
//   out_data   working registers, same packing; valid while out_valid=1
//   swap_cnt   exchanges performed on the current packet (0..5)
//   busy       high in SORT or DONE
module cmp_sort4_ctrl #(
    parameter int unsigned WIDTH   = 4,
    parameter bit          DESCEND = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [2:0]         swap_cnt,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [2:0]       step;
    logic [WIDTH-1:0] elem [4];

    logic [1:0]       idx_a;
    logic [1:0]       idx_b;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             do_swap;
    logic             last_step;

    // Network schedule: which register pair the shared comparator sees.
    always_comb begin
        idx_a = 2'd1;
        idx_b = 2'd2;
        case (step)
            3'd0: begin idx_a = 2'd0; idx_b = 2'd1; end
            3'd1: begin idx_a = 2'd2; idx_b = 2'd3; end
            3'd2: begin idx_a = 2'd0; idx_b = 2'd2; end
            3'd3: begin idx_a = 2'd1; idx_b = 2'd3; end
            default: begin idx_a = 2'd1; idx_b = 2'd2; end
        endcase
    end

    // Shared comparator
    always_comb begin
        val_a   = elem[idx_a];
        val_b   = elem[idx_b];
        gt      = (val_a > val_b);
        eq      = (val_a == val_b);
        lt      = (val_a < val_b);
        do_swap = !eq && (DESCEND ? lt : gt);
    end

    assign last_step = (step == 3'd4);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = SORT;
            SORT:    if (last_step) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            SORT:    busy      = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: capture, compare-exchange, step and swap counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem     <= '{default: '0};
            step     <= '0;
            swap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            elem[i] <= in_data[i*WIDTH +: WIDTH];
                        end
                        step     <= '0;
                        swap_cnt <= '0;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        elem[idx_a] <= val_b;
                        elem[idx_b] <= val_a;
                        swap_cnt    <= swap_cnt + 3'd1;
                    end
                    if (!last_step) begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            out_data[i*WIDTH +: WIDTH] = elem[i];
        end
    end

endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// Self-checking bench for cmp_sort4_ctrl: an ascending WIDTH=4 instance and a
// descending WIDTH=8 instance share clock and reset.
module tb_cmp_sort4_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] in_data, out_data;
    logic [2:0]  swap_cnt;

    logic        in_valid_d, in_ready_d, out_valid_d, out_ready_d, busy_d;
    logic [31:0] in_data_d, out_data_d;
    logic [2:0]  swap_cnt_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_sort4_ctrl #(.WIDTH(4), .DESCEND(1'b0)) u_asc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .swap_cnt(swap_cnt), .busy(busy)
    );

    cmp_sort4_ctrl #(.WIDTH(8), .DESCEND(1'b1)) u_desc (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d),
        .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d),
        .swap_cnt(swap_cnt_d), .busy(busy_d)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pk(input int d0, input int d1, input int d2, input int d3);
        logic [15:0] r;
        r = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
        return r;
    endfunction

    // Reference: output is the plain sorted multiset; swap count follows the
    // network's compare-exchange sequence applied to an integer array.
    task automatic ref_sort(input logic [15:0] din, output logic [15:0] dout, output logic [2:0] cnt);
        int v[4];
        int s[4];
        int pa[5] = '{0, 2, 0, 1, 1};
        int pb[5] = '{1, 3, 2, 3, 2};
        int t;
        int c;
        for (int i = 0; i < 4; i++) begin
            v[i] = int'(din[i*4 +: 4]);
            s[i] = v[i];
        end
        for (int i = 1; i < 4; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        c = 0;
        for (int k = 0; k < 5; k++) begin
            if (v[pa[k]] > v[pb[k]]) begin
                t = v[pa[k]]; v[pa[k]] = v[pb[k]]; v[pb[k]] = t;
                c++;
            end
        end
        dout = pk(s[0], s[1], s[2], s[3]);
        cnt  = c[2:0];
    endtask

    // One full packet on the ascending instance: handshake, exact latency,
    // optional DONE backpressure, release back to IDLE.
    task automatic run_packet(input logic [15:0] din, input int hold,
                              output logic [15:0] dout, output logic [2:0] cnt);
        @(negedge clk);
        in_data  = din;
        in_valid = 1'b1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("latency_out_valid", {31'd0, out_valid}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("busy_done", {31'd0, busy}, 32'd1);
        check("in_ready_done", {31'd0, in_ready}, 32'd0);
        dout = out_data;
        cnt  = swap_cnt;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_data", {16'd0, out_data}, {16'd0, dout});
            check("hold_cnt", {29'd0, swap_cnt}, {29'd0, cnt});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
        check({tag, "_swap_cnt"}, {29'd0, swap_cnt}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] got_d, exp_d, held_d;
        logic [2:0]  got_c, exp_c, held_c;

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid_d = 1'b0; in_data_d = '0; out_ready_d = 1'b0;

        vecs[0] = '{din: pk(9, 3, 3, 0),   dout: pk(0, 3, 3, 9),   cnt: 3'd4};
        vecs[1] = '{din: pk(1, 2, 3, 4),   dout: pk(1, 2, 3, 4),   cnt: 3'd0};
        vecs[2] = '{din: pk(15, 10, 5, 0), dout: pk(0, 5, 10, 15), cnt: 3'd4};
        vecs[3] = '{din: pk(2, 3, 0, 1),   dout: pk(0, 1, 2, 3),   cnt: 3'd2};
        vecs[4] = '{din: pk(7, 7, 7, 7),   dout: pk(7, 7, 7, 7),   cnt: 3'd0};
        vecs[5] = '{din: pk(15, 15, 0, 0), dout: pk(0, 0, 15, 15), cnt: 3'd2};

        #2;
        check_reset_outputs("reset_initial");
        check("reset_desc_valid", {31'd0, out_valid_d}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[k]) begin
            run_packet(vecs[k].din, k % 2, got_d, got_c);
            check($sformatf("vec%0d_data", k), {16'd0, got_d}, {16'd0, vecs[k].dout});
            check($sformatf("vec%0d_cnt", k), {29'd0, got_c}, {29'd0, vecs[k].cnt});
        end

        // Backpressure: three DONE cycles with in_valid high and new data
        run_packet(pk(9, 3, 3, 0), 3, got_d, got_c);
        check("bp_data", {16'd0, got_d}, {16'd0, pk(0, 3, 3, 9)});
        check("bp_cnt", {29'd0, got_c}, 32'd4);

        // Descending WIDTH=8 instance
        @(negedge clk);
        in_data_d  = {8'h80, 8'h00, 8'hFF, 8'h10};
        in_valid_d = 1'b1;
        @(posedge clk);
        #1;
        in_valid_d = 1'b0;
        in_data_d  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("desc_latency", {31'd0, out_valid_d}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("desc_data", out_data_d, {8'h00, 8'h10, 8'h80, 8'hFF});
        check("desc_cnt", {29'd0, swap_cnt_d}, 32'd3);
        out_ready_d = 1'b1;
        @(posedge clk);
        #1;
        out_ready_d = 1'b0;
        check("desc_release", {31'd0, in_ready_d}, 32'd1);

        // Reset pulse during SORT step 2, between clock edges
        @(negedge clk);
        in_data  = pk(15, 10, 5, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_sort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_sort");
        @(negedge clk);
        rst_n = 1'b1;
        run_packet(pk(2, 3, 0, 1), 0, got_d, got_c);
        check("after_reset_data", {16'd0, got_d}, {16'd0, pk(0, 1, 2, 3)});
        check("after_reset_cnt", {29'd0, got_c}, 32'd2);

        // Reset while holding in DONE
        @(negedge clk);
        in_data  = pk(9, 3, 3, 0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("done_before_reset", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_done");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized packets against the reference model
        for (int r = 0; r < 30; r++) begin
            held_d = 16'($urandom);
            ref_sort(held_d, exp_d, exp_c);
            run_packet(held_d, int'($urandom_range(0, 2)), got_d, got_c);
            check("rand_data", {16'd0, got_d}, {16'd0, exp_d});
            check("rand_cnt", {29'd0, got_c}, {29'd0, exp_c});
            held_c = got_c;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
